// File: rtl/nco_pkg.sv
// Shared definitions for the NCO: default accumulator width, the quarter-wave
// sine table and the quadrant-folding sample function.
package nco_pkg;

    localparam int ACC_WIDTH_DEF = 16;
    localparam int QW_DEPTH      = 64;

    // Q[k] = round(127*sin(2*pi*(k+0.5)/256)); half-step offset keeps the folded wave symmetric
    localparam logic [6:0] QTABLE [0:QW_DEPTH-1] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    function automatic logic [7:0] sine8(input logic [7:0] addr);
        logic [5:0] idx;
        logic [7:0] mag;
        // odd quadrants read the table mirrored; 63-i is the bitwise inverse of i
        if (addr[6]) begin
            idx = ~addr[5:0];
        end else begin
            idx = addr[5:0];
        end
        mag = {1'b0, QTABLE[idx]};
        if (addr[7]) begin
            sine8 = 8'd127 - mag;
        end else begin
            sine8 = 8'd128 + mag;
        end
    endfunction

endpackage

// File: rtl/nco_sine_lut.sv
// Combinational quarter-wave sine lookup: 8-bit phase address to an 8-bit
// offset-binary sample.
module nco_sine_lut
    import nco_pkg::*;
(
    input  logic [7:0] addr,
    output logic [7:0] sample
);

    always_comb begin
        sample = sine8(addr);
    end

endmodule

// File: rtl/nco.sv
// Numerically controlled oscillator: phase accumulator, phase-offset adder,
// sine lookup and registered output sample.
module nco
    import nco_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] phase,
    input  logic [5:0] freq_res,
    output logic [7:0] out
);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [7:0]           out_q;
    logic [7:0]           out_d;
    logic [7:0]           addr_s;
    logic [7:0]           sample_s;

    // address uses the accumulator value before this edge's increment
    always_comb begin
        addr_s = acc_q[ACC_WIDTH-1 -: 8] + phase;
    end

    nco_sine_lut u_lut (
        .addr   (addr_s),
        .sample (sample_s)
    );

    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        if (rst) begin
            acc_d = '0;
            out_d = 8'h80;
        end else begin
            acc_d = acc_q + {{(ACC_WIDTH-6){1'b0}}, freq_res};
            out_d = sample_s;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_nco.sv
// Directed self-checking bench for the nco block with a cycle-level reference model.
module tb_nco;

    logic       clk;
    logic       rst;
    logic [7:0] phase;
    logic [5:0] freq_res;
    logic [7:0] dout;

    int checks;
    int failures;

    logic [15:0] m_acc;
    logic [7:0]  m_out;

    int q_tab [0:63] = '{
        2,   5,   8,   11,  14,  17,  20,  23,
        26,  29,  32,  35,  38,  41,  44,  47,
        50,  53,  56,  58,  61,  64,  67,  69,
        72,  74,  77,  79,  82,  84,  86,  89,
        91,  93,  95,  97,  99,  101, 103, 105,
        106, 108, 110, 111, 113, 114, 115, 117,
        118, 119, 120, 121, 122, 123, 124, 124,
        125, 125, 126, 126, 127, 127, 127, 127
    };

    nco #(.ACC_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .phase    (phase),
        .freq_res (freq_res),
        .out      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_sine(input logic [7:0] a);
        int i;
        int v;
        i = int'(a[5:0]);
        case (a[7:6])
            2'd0:    v = 128 + q_tab[i];
            2'd1:    v = 128 + q_tab[63 - i];
            2'd2:    v = 127 - q_tab[i];
            default: v = 127 - q_tab[63 - i];
        endcase
        return v[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_acc = 16'd0;
            m_out = 8'h80;
        end else begin
            m_out = m_sine(m_acc[15:8] + phase);
            m_acc = m_acc + {10'd0, freq_res};
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        phase    = 8'h5A;
        freq_res = 6'd5;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (dout !== 8'h80) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d got=%h exp=80", c, dout);
            end
        end
        rst      = 1'b0;
        phase    = 8'h23;
        freq_res = 6'd0;
        tick();
        checks++;
        if (dout !== 8'hE1) begin
            failures++;
            $display("FAIL reset_release got=%h exp=e1", dout);
        end
    endtask

    task automatic test_static_phase();
        logic [7:0] ph [0:3];
        logic [7:0] ex [0:3];
        int bad;
        ph = '{8'h00, 8'h40, 8'h80, 8'hC0};
        ex = '{8'h82, 8'hFF, 8'h7D, 8'h00};
        do_reset();
        freq_res = 6'd0;
        for (int v = 0; v < 4; v++) begin
            phase = ph[v];
            bad   = 0;
            for (int c = 0; c < 100; c++) begin
                tick();
                checks++;
                if (dout !== ex[v]) begin
                    failures++;
                    bad++;
                    if (bad < 4) $display("FAIL static_phase ph=%h cycle=%0d got=%h exp=%h", ph[v], c, dout, ex[v]);
                end
            end
        end
    endtask

    task automatic test_slow_sweep();
        int bad;
        bad = 0;
        phase    = 8'h00;
        freq_res = 6'd0;
        do_reset();
        freq_res = 6'd1;
        for (int e = 1; e <= 17000; e++) begin
            tick();
            checks++;
            if (dout !== m_out) begin
                failures++;
                bad++;
                if (bad < 6) $display("FAIL slow_sweep edge=%0d got=%h exp=%h", e, dout, m_out);
            end
            if (e == 16385) begin
                checks++;
                if (dout !== 8'hFF) begin
                    failures++;
                    $display("FAIL slow_sweep_peak edge=%0d got=%h exp=ff", e, dout);
                end
            end
        end
    endtask

    task automatic test_fast_wrap();
        int bad;
        bad = 0;
        phase    = 8'h00;
        freq_res = 6'd0;
        do_reset();
        freq_res = 6'd63;
        for (int e = 1; e <= 5000; e++) begin
            tick();
            checks++;
            if (dout !== m_out) begin
                failures++;
                bad++;
                if (bad < 6) $display("FAIL fast_sweep edge=%0d got=%h exp=%h", e, dout, m_out);
            end
            // acc=65520 just before wrap, then 65583 mod 65536 = 47
            if (e == 1041) begin
                checks++;
                if (dout !== 8'h7D) begin
                    failures++;
                    $display("FAIL fast_prewrap edge=%0d got=%h exp=7d", e, dout);
                end
            end
            if (e == 1042) begin
                checks++;
                if (dout !== 8'h82) begin
                    failures++;
                    $display("FAIL fast_wrap edge=%0d got=%h exp=82", e, dout);
                end
            end
        end
    endtask

    task automatic test_antisymmetry();
        logic [7:0] s [0:255];
        int bad;
        int sum;
        bad = 0;
        freq_res = 6'd0;
        phase    = 8'h00;
        do_reset();
        for (int a = 0; a < 256; a++) begin
            phase = 8'(a);
            tick();
            s[a] = dout;
            checks++;
            if (dout !== m_sine(8'(a))) begin
                failures++;
                bad++;
                if (bad < 6) $display("FAIL sine_table addr=%h got=%h exp=%h", a[7:0], dout, m_sine(8'(a)));
            end
        end
        for (int a = 0; a < 128; a++) begin
            sum = int'(s[a]) + int'(s[a + 128]);
            checks++;
            if (sum != 255) begin
                failures++;
                bad++;
                if (bad < 10) $display("FAIL antisymmetry addr=%h got=%0d exp=255", a[7:0], sum);
            end
        end
    endtask

    task automatic test_midrun();
        int bad;
        bad = 0;
        phase    = 8'h00;
        freq_res = 6'd0;
        do_reset();
        freq_res = 6'd15;
        for (int e = 0; e < 300; e++) begin
            tick();
            checks++;
            if (dout !== m_out) begin
                failures++;
                bad++;
                if (bad < 4) $display("FAIL midrun_run edge=%0d got=%h exp=%h", e, dout, m_out);
            end
        end
        phase = 8'h23;
        tick();
        checks++;
        if (dout !== m_out) begin
            failures++;
            $display("FAIL midrun_phase_step got=%h exp=%h", dout, m_out);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (dout !== 8'h80) begin
            failures++;
            $display("FAIL midrun_reset got=%h exp=80", dout);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dout !== 8'hE1) begin
            failures++;
            $display("FAIL midrun_release got=%h exp=e1", dout);
        end
        tick();
        checks++;
        if (dout !== m_out) begin
            failures++;
            $display("FAIL midrun_resume got=%h exp=%h", dout, m_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_acc    = 16'd0;
        m_out    = 8'h80;
        rst      = 1'b1;
        phase    = 8'h00;
        freq_res = 6'd0;
        test_reset();
        test_static_phase();
        test_slow_sweep();
        test_fast_wrap();
        test_antisymmetry();
        test_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
